lsu_dmem_if: RTL and testbench

- Load/store unit directly downstream of the ALU.
- Takes the ALU result as the effective address for RV32I loads and stores. Drives a request/grant/response data-memory bus.
- Returns load data that is sign- or zero-extended. Stalls the single-cycle core with a busy signal until the access completes.
- Handles byte-lane steering, write strobes, misalignment and bus errors.

---
 rtl/lsu_dmem_if_if.sv | 24 ++
 rtl/lsu_dmem_if.sv | 188 ++++++++++++++++++
 tb/tb_lsu_dmem_if.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_dmem_if_if.sv
// Data-memory request/grant/response bus between the LSU and memory.
// Latency: none (wires only).
// Backpressure: mem_gnt accepts a held request; one response per granted request.
interface lsu_dmem_if_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_err
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata, mem_err
    );
endinterface

// File: rtl/lsu_dmem_if.sv
// RV32I load/store unit driving a req/gnt/rvalid data bus; LSU_BUS_TIMEOUT_EN adds a bus-wait abort counter.
// Latency: 3 cycles minimum (REQ, WAIT, DONE); misaligned/illegal accesses complete in 1 cycle.
// Backpressure: lsu_busy stalls the core until lsu_done; the request is held until mem_gnt.
module lsu_dmem_if #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_is_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        lsu_busy,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_misalign,
    output logic        lsu_fault,
    lsu_dmem_if_if.master dmem
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    logic        store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;

    logic        is_half;
    logic        is_word;
    logic        illegal;
    logic        misalign;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;

    always_comb begin
        is_half  = (ex_funct3[1:0] == 2'b01);
        is_word  = (ex_funct3[1:0] == 2'b10);
        if (ex_is_store)
            illegal = (ex_funct3 >= 3'd3);
        else
            illegal = (ex_funct3 == 3'd3) || (ex_funct3 == 3'd6) || (ex_funct3 == 3'd7);
        // Alignment is only meaningful for a legal access width.
        misalign = !illegal && ((is_half && ex_addr[0]) || (is_word && (ex_addr[1:0] != 2'b00)));
    end

    always_comb begin
        st_wdata = ex_wdata;
        st_wstrb = 4'b1111;
        case (ex_funct3[1:0])
            2'b00: begin
                st_wdata = {4{ex_wdata[7:0]}};
                st_wstrb = 4'b0001 << ex_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{ex_wdata[15:0]}};
                st_wstrb = ex_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lo,
                                                input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {lo, 3'b000});
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return word;
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return 32'd0;
        endcase
    endfunction

    assign lsu_busy = ((state == IDLE) && ex_valid) || (state == REQ) || (state == WAIT);

`ifdef LSU_BUS_TIMEOUT_EN
    localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 32) ? 32 : CW_RAW);

    logic [CW-1:0] to_cnt;
    logic          to_hit;

    // Counter is 0 in the first REQ cycle, so the abort lands TIMEOUT_CYCLES cycles after REQ entry.
    assign to_hit = (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_param;
    assign unused_timeout_param = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            store_q        <= 1'b0;
            funct3_q       <= 3'd0;
            addr_lo_q      <= 2'd0;
            dmem.mem_req   <= 1'b0;
            dmem.mem_we    <= 1'b0;
            dmem.mem_addr  <= 32'd0;
            dmem.mem_wdata <= 32'd0;
            dmem.mem_wstrb <= 4'd0;
            lsu_done       <= 1'b0;
            lsu_rdata      <= 32'd0;
            lsu_misalign   <= 1'b0;
            lsu_fault      <= 1'b0;
`ifdef LSU_BUS_TIMEOUT_EN
            to_cnt         <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    lsu_done     <= 1'b0;
                    lsu_rdata    <= 32'd0;
                    lsu_misalign <= 1'b0;
                    lsu_fault    <= 1'b0;
                    if (ex_valid) begin
                        store_q   <= ex_is_store;
                        funct3_q  <= ex_funct3;
                        addr_lo_q <= ex_addr[1:0];
                        if (illegal || misalign) begin
                            state        <= DONE;
                            lsu_done     <= 1'b1;
                            lsu_fault    <= illegal;
                            lsu_misalign <= misalign;
                        end else begin
                            state          <= REQ;
                            dmem.mem_req   <= 1'b1;
                            dmem.mem_we    <= ex_is_store;
                            dmem.mem_addr  <= {ex_addr[31:2], 2'b00};
                            dmem.mem_wdata <= ex_is_store ? st_wdata : 32'd0;
                            dmem.mem_wstrb <= ex_is_store ? st_wstrb : 4'd0;
`ifdef LSU_BUS_TIMEOUT_EN
                            to_cnt         <= '0;
`endif
                        end
                    end
                end
                REQ: begin
                    if (dmem.mem_gnt) begin
                        dmem.mem_req <= 1'b0;
                        state        <= WAIT;
                    end
`ifdef LSU_BUS_TIMEOUT_EN
                    else if (to_hit) begin
                        dmem.mem_req <= 1'b0;
                        state        <= DONE;
                        lsu_done     <= 1'b1;
                        lsu_fault    <= 1'b1;
                    end
                    to_cnt <= to_cnt + 1'b1;
`endif
                end
                WAIT: begin
                    if (dmem.mem_rvalid) begin
                        state     <= DONE;
                        lsu_done  <= 1'b1;
                        lsu_fault <= dmem.mem_err;
                        lsu_rdata <= (dmem.mem_err || store_q) ? 32'd0
                                   : load_extend(dmem.mem_rdata, addr_lo_q, funct3_q);
                    end
`ifdef LSU_BUS_TIMEOUT_EN
                    else if (to_hit) begin
                        state     <= DONE;
                        lsu_done  <= 1'b1;
                        lsu_fault <= 1'b1;
                    end
                    to_cnt <= to_cnt + 1'b1;
`endif
                end
                DONE: begin
                    // ex_valid is still the retiring instruction here; never restart from DONE.
                    state        <= IDLE;
                    lsu_done     <= 1'b0;
                    lsu_rdata    <= 32'd0;
                    lsu_misalign <= 1'b0;
                    lsu_fault    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dmem_if.sv
// Scoreboarded bench for lsu_dmem_if: byte-level memory model, randomized loads/stores, bus responder.
module tb_lsu_dmem_if;

`ifdef LSU_BUS_TIMEOUT_EN
    localparam int unsigned TO   = 4;
    localparam int          MAXD = 1;
    localparam int          GD5  = 2;
`else
    localparam int unsigned TO   = 255;
    localparam int          MAXD = 3;
    localparam int          GD5  = 5;
`endif

    logic        clk;
    logic        rst_n;
    logic        ex_valid, ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic        lsu_busy, lsu_done, lsu_misalign, lsu_fault;
    logic [31:0] lsu_rdata;

    lsu_dmem_if_if dmem();

    lsu_dmem_if #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_is_store(ex_is_store), .ex_funct3(ex_funct3),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
        .lsu_misalign(lsu_misalign), .lsu_fault(lsu_fault),
        .dmem(dmem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h want %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus responder: automatic in normal mode, driven by the main thread in manual mode.
    logic        resp_en;
    logic        r_gnt, r_rvalid, r_err, man_gnt, man_rvalid, man_err;
    logic [31:0] r_rdata, man_rdata;
    assign dmem.mem_gnt    = resp_en ? r_gnt    : man_gnt;
    assign dmem.mem_rvalid = resp_en ? r_rvalid : man_rvalid;
    assign dmem.mem_err    = resp_en ? r_err    : man_err;
    assign dmem.mem_rdata  = resp_en ? r_rdata  : man_rdata;

    int cur_gdly, cur_rdly;
    bit cur_err;

    typedef struct {logic [31:0] rdata; logic mis; logic flt;} exp_t;
    typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] wstrb;} bus_t;
    exp_t sb[$];
    bus_t bus_exp[$];

    logic [7:0]  ref_mem [bit [31:0]];
    logic [31:0] bus_mem [bit [31:0]];

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return 8'(a * 32'd37 + 32'd11);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    function automatic logic [31:0] bus_word(input logic [31:0] wa);
        if (bus_mem.exists(wa)) return bus_mem[wa];
        return {init_byte(wa + 3), init_byte(wa + 2), init_byte(wa + 1), init_byte(wa)};
    endfunction

    task automatic preload(input logic [31:0] wa, input logic [31:0] w);
        bus_mem[wa] = w;
        for (int i = 0; i < 4; i++) ref_mem[wa + i] = w[8*i +: 8];
    endtask

    initial begin : responder
        bit          pend;
        int          gcnt, rcnt;
        logic [31:0] p_addr, p_wdata, w;
        logic [3:0]  p_strb;
        logic        p_we;
        bus_t        b;
        pend = 0; gcnt = 0; rcnt = 0;
        r_gnt = 0; r_rvalid = 0; r_err = 0; r_rdata = 0;
        forever begin
            @(negedge clk);
            r_gnt = 0; r_rvalid = 0; r_err = 0; r_rdata = $urandom;
            if (!resp_en) begin
                pend = 0; gcnt = 0; rcnt = 0;
            end else if (pend) begin
                chk("req_dropped_after_gnt", 32'(dmem.mem_req), 32'd0);
                if (rcnt < cur_rdly) rcnt++;
                else begin
                    r_rvalid = 1; r_err = cur_err; pend = 0;
                    if (!cur_err && !p_we) r_rdata = bus_word(p_addr);
                    if (!cur_err && p_we) begin
                        w = bus_word(p_addr);
                        for (int i = 0; i < 4; i++) if (p_strb[i]) w[8*i +: 8] = p_wdata[8*i +: 8];
                        bus_mem[p_addr] = w;
                    end
                end
            end else if (dmem.mem_req) begin
                if (bus_exp.size() == 0) chk("unexpected_mem_req", 32'(dmem.mem_req), 32'd0);
                else begin
                    b = bus_exp[0];
                    chk("mem_addr", dmem.mem_addr, b.addr);
                    chk("mem_we", 32'(dmem.mem_we), 32'(b.we));
                    chk("mem_wstrb", 32'(dmem.mem_wstrb), 32'(b.wstrb));
                    if (b.we) chk("mem_wdata", dmem.mem_wdata, b.wdata);
                    if (gcnt < cur_gdly) gcnt++;
                    else begin
                        r_gnt = 1; pend = 1; rcnt = 0; gcnt = 0;
                        p_addr = dmem.mem_addr; p_we = dmem.mem_we;
                        p_wdata = dmem.mem_wdata; p_strb = dmem.mem_wstrb;
                        void'(bus_exp.pop_front());
                    end
                end
            end else gcnt = 0;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (lsu_done === 1'b1) begin
                if (sb.size() == 0) chk("unexpected_lsu_done", 32'(lsu_done), 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("lsu_rdata", lsu_rdata, e.rdata);
                    chk("lsu_misalign", 32'(lsu_misalign), 32'(e.mis));
                    chk("lsu_fault", 32'(lsu_fault), 32'(e.flt));
                    chk("busy_in_done", 32'(lsu_busy), 32'd0);
                end
            end
        end
    end

    // Reference model + drive one instruction; returns cycles from presentation to lsu_done.
    task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit err, input int gdly, input int rdly,
                         input bit exp_to, output int lat);
        bit illegal, mis, done;
        int size;
        exp_t e;
        bus_t b;
        logic [31:0] v;
        illegal = st ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        size = 1 << f3[1:0];
        mis = !illegal && ((addr % size) != 0);
        e.rdata = 32'd0; e.mis = 1'b0; e.flt = 1'b0;
        if (illegal) e.flt = 1'b1;
        else if (mis) e.mis = 1'b1;
        else begin
            b.addr = addr & ~32'd3; b.we = st; b.wstrb = 4'd0; b.wdata = 32'd0;
            if (st) begin
                for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
                for (int i = 0; i < size; i++) b.wstrb[(addr % 4) + i] = 1'b1;
            end
            bus_exp.push_back(b);
            if (exp_to || err) e.flt = 1'b1;
            else if (st) for (int i = 0; i < size; i++) ref_mem[addr + i] = wdata[8*i +: 8];
            else begin
                v = 32'd0;
                for (int i = 0; i < size; i++) v[8*i +: 8] = ref_byte(addr + i);
                if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
                e.rdata = v;
            end
        end
        sb.push_back(e);
        cur_err = err; cur_gdly = gdly; cur_rdly = rdly;
        @(negedge clk);
        ex_is_store = st; ex_funct3 = f3; ex_addr = addr; ex_wdata = wdata; ex_valid = 1'b1;
        #1 chk("busy_cycle0", 32'(lsu_busy), 32'd1);
        lat = 0; done = 0;
        while (!done && lat < 400) begin
            @(negedge clk);
            lat++;
            if (lsu_done === 1'b1) done = 1;
            else chk("busy_hold", 32'(lsu_busy), 32'd1);
        end
        if (!done) chk("lsu_done_within_bound", 32'd0, 32'd1);
        @(negedge clk);
        ex_valid = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mem_req"}, 32'(dmem.mem_req), 32'd0);
        chk({tag, "_mem_we"}, 32'(dmem.mem_we), 32'd0);
        chk({tag, "_mem_addr"}, dmem.mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, dmem.mem_wdata, 32'd0);
        chk({tag, "_mem_wstrb"}, 32'(dmem.mem_wstrb), 32'd0);
        chk({tag, "_lsu_done"}, 32'(lsu_done), 32'd0);
        chk({tag, "_lsu_rdata"}, lsu_rdata, 32'd0);
        chk({tag, "_lsu_misalign"}, 32'(lsu_misalign), 32'd0);
        chk({tag, "_lsu_fault"}, 32'(lsu_fault), 32'd0);
        chk({tag, "_lsu_busy"}, 32'(lsu_busy), 32'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vec_cnt);
        $fatal(1);
    end

    initial begin : stimulus
        int lat;
        rst_n = 1'b0; ex_valid = 1'b0; ex_is_store = 1'b0; ex_funct3 = 3'd0;
        ex_addr = 32'd0; ex_wdata = 32'd0; resp_en = 1'b1;
        man_gnt = 1'b0; man_rvalid = 1'b0; man_err = 1'b0; man_rdata = 32'd0;
        cur_err = 0; cur_gdly = 0; cur_rdly = 0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        preload(32'h100, 32'hDEADBEEF);
        issue(0, 3'd2, 32'h100, 32'd0, 0, 0, 0, 0, lat);
        chk("lw_min_latency", 32'(lat), 32'd3);
        preload(32'h100, 32'h80FF_0000);
        issue(0, 3'd0, 32'h103, 32'd0, 0, 0, 0, 0, lat);
        issue(0, 3'd4, 32'h103, 32'd0, 0, 0, 0, 0, lat);
        issue(1, 3'd1, 32'h202, 32'h1234ABCD, 0, 0, 0, 0, lat);
        issue(0, 3'd2, 32'h200, 32'd0, 0, 0, 0, 0, lat);
        issue(0, 3'd2, 32'h101, 32'd0, 0, 0, 0, 0, lat);
        chk("misalign_latency", 32'(lat), 32'd1);
        issue(0, 3'd2, 32'h104, 32'd0, 1, GD5, 0, 0, lat);
        issue(1, 3'd3, 32'h108, 32'h5555AAAA, 0, 0, 0, 0, lat);
        chk("illegal_latency", 32'(lat), 32'd1);

        // Reset while WAIT, then a stray response that must be ignored.
        resp_en = 1'b0;
        @(negedge clk);
        ex_is_store = 1'b0; ex_funct3 = 3'd2; ex_addr = 32'h100; ex_valid = 1'b1;
        @(negedge clk);
        chk("rst_test_req", 32'(dmem.mem_req), 32'd1);
        man_gnt = 1'b1;
        @(negedge clk);
        man_gnt = 1'b0; rst_n = 1'b0; ex_valid = 1'b0;
        @(negedge clk);
        chk_zero("midreset");
        rst_n = 1'b1; man_rvalid = 1'b1; man_rdata = 32'hCAFEF00D;
        @(negedge clk);
        man_rvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stray_rvalid_done", 32'(lsu_done), 32'd0);
            chk("stray_rvalid_rdata", lsu_rdata, 32'd0);
        end
        resp_en = 1'b1;

`ifdef LSU_BUS_TIMEOUT_EN
        issue(0, 3'd2, 32'h100, 32'd0, 0, 1000, 0, 1, lat);
        chk("timeout_latency", 32'(lat), 32'd5);
        bus_exp.delete();
`endif

        for (int n = 0; n < 300; n++) begin
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  32'h100 + 32'($urandom_range(0, 63)), $urandom,
                  ($urandom_range(0, 7) == 0), $urandom_range(0, MAXD),
                  $urandom_range(0, MAXD), 0, lat);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        chk("bus_queue_drained", 32'(bus_exp.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
